// File: rtl/fifo_sync_prog_if.sv
// Handshake and status bundle for fifo_sync_prog.
// The FIFO takes the slave modport and the producer/consumer side takes master.
interface fifo_sync_prog_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned ADDR = $clog2(DEPTH);

    logic [WIDTH-1:0] data_in;
    logic             wr_en;
    logic             rd_en;
    logic             err_clr;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [ADDR:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output data_in, wr_en, rd_en, err_clr,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  data_in, wr_en, rd_en, err_clr,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with programmable almost flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered read data.
module fifo_sync_prog #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 14,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_sync_prog_if.slave       bus
);
    localparam int unsigned ADDR = $clog2(DEPTH);
    localparam logic [ADDR:0] AF_LVL = AF_THRESH[ADDR:0];
    localparam logic [ADDR:0] AE_LVL = AE_THRESH[ADDR:0];

    logic [WIDTH-1:0] mem [DEPTH];

    logic [ADDR:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          full, empty;
    logic          wr_acc, rd_acc;

    // Wrap bit distinguishes full from empty when the low address bits match.
    assign full  = (wr_ptr_q[ADDR] != rd_ptr_q[ADDR]) &&
                   (wr_ptr_q[ADDR-1:0] == rd_ptr_q[ADDR-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign rd_acc = bus.rd_en && !empty;
    assign wr_acc = bus.wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new error in the same cycle as err_clr wins.
        overflow_d  = (bus.wr_en && !wr_acc) || (overflow_q && !bus.err_clr);
        underflow_d = (bus.rd_en && !rd_acc) || (underflow_q && !bus.err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q[ADDR-1:0]] <= bus.data_in;
    end

`ifdef FIFO_FWFT_EN
    // Gate on empty so a reset or drained FIFO presents zero rather than stale memory.
    assign bus.data_out   = empty ? '0 : mem[rd_ptr_q[ADDR-1:0]];
    assign bus.data_valid = !empty;
`else
    logic [WIDTH-1:0] data_out_q;
    logic             data_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            if (rd_acc) data_out_q <= mem[rd_ptr_q[ADDR-1:0]];
            data_valid_q <= rd_acc;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AF_LVL);
    assign bus.almost_empty = (count_q <= AE_LVL);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: doc/fifo_sync_prog.md
FIFO_SYNC_PROG -- requirements
Module: fifo_sync_prog

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16: number of entries, a power of two and at least 4.
REQ-003 The block SHALL have parameter AF_THRESH, default 14: almost_full asserts when count >= AF_THRESH.
REQ-004 The block SHALL have parameter AE_THRESH, default 2: almost_empty asserts when count <= AE_THRESH.
REQ-005 The block SHALL derive local ADDR = log2(DEPTH), which is not user-settable.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port data_in, input, WIDTH bits: write data.
REQ-009 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-010 The block SHALL have port rd_en, input, 1 bit: read request (pop).
REQ-011 The block SHALL have port err_clr, input, 1 bit: synchronous clear of the sticky error flags.
REQ-012 The block SHALL have port data_out, output, WIDTH bits: read data.
REQ-013 The block SHALL have port data_valid, output, 1 bit: data_out holds a valid word.
REQ-014 The block SHALL have ports full and empty, output, 1 bit each: occupancy is DEPTH and 0 respectively.
REQ-015 The block SHALL have ports almost_full and almost_empty, output, 1 bit each: threshold flags.
REQ-016 The block SHALL have port count, output, ADDR+1 bits: current occupancy, 0..DEPTH.
REQ-017 The block SHALL have ports overflow and underflow, output, 1 bit each: sticky error flags.

Function
REQ-018 Pointers SHALL be ADDR+1 bits wide, with the MSB used as a wrap bit; full = MSBs differ and low bits are equal; empty = pointers equal.
REQ-019 A read SHALL be accepted when rd_en=1 and empty=0.
REQ-020 A write SHALL be accepted when wr_en=1 and either full=0 or a read is accepted in the same cycle (write-through-full allowed).
REQ-021 An accepted write SHALL store data_in at wr_ptr and increment wr_ptr; an accepted read SHALL increment rd_ptr; pointers SHALL wrap modulo 2*DEPTH.
REQ-022 count SHALL be registered: +1 on a write only, -1 on a read only, unchanged when both or neither are accepted.
REQ-023 full, empty, almost_full and almost_empty SHALL be combinational from the registered pointers and count; their values SHALL be consistent with count in the same cycle.
REQ-024 When wr_en=1 is rejected, overflow SHALL set on the next edge; when rd_en=1 is rejected, underflow SHALL set on the next edge; both SHALL hold until err_clr=1 or reset.
REQ-025 If err_clr=1 and a new error occur in the same cycle, the flag SHALL end the cycle set (set wins).
REQ-026 When empty, a simultaneous wr_en and rd_en SHALL accept the write, reject the read, and set underflow.
REQ-027 Rejected requests SHALL NOT change memory, pointers or count.

Reset
REQ-028 While rst=1, asynchronously: pointers=0, count=0, data_out=0, data_valid=0, overflow=0, underflow=0, so empty=1, almost_empty=1, full=0, almost_full=0.
REQ-029 Memory contents SHALL NOT be reset; a reset asserted mid-operation SHALL discard all stored words.

Configuration
REQ-030 With macro FIFO_FWFT_EN defined: first-word-fall-through; data_out = mem[rd_ptr] combinationally, data_valid = !empty, and rd_en acknowledges/pops the displayed word.
REQ-031 Without FIFO_FWFT_EN: standard mode; data_out is registered with mem[rd_ptr] on an accepted read (1-cycle latency), is held otherwise, and data_valid pulses high for exactly one cycle after each accepted read.

Verification
REQ-032 Reset, then write 0x01..0x10 (16 words) -> full=1, count=16, almost_full from count 14; a 17th write -> overflow=1 and count stays 16.
REQ-033 Read 16 words -> data 0x01..0x10 in order (standard: 1-cycle latency, data_valid pulses; FWFT: 0x01 visible before the first rd_en); then empty=1; an extra rd_en -> underflow=1.
REQ-034 When full, wr_en=rd_en=1 with data_in=0xAA -> head popped, 0xAA stored, count stays 16, full stays 1, overflow stays 0.
REQ-035 Stream 40 words with continuous write/read interleave -> pointer wrap, data integrity preserved, count never exceeds 16.
REQ-036 Set both error flags, pulse err_clr -> both clear next cycle; err_clr together with a rejected write -> overflow remains 1.
REQ-037 Assert rst asynchronously mid-stream at count=9 -> all outputs take reset values immediately, without waiting for a clock edge.
